// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: types and constants shared by the instruction fetch stage.
//   int32_t        - 32-bit machine word (addresses and instructions)
//   BUBBLE         - value driven on Inst/PC when no instruction is valid
//   fetch_state_e  - fetch FSM encoding (BOOT / RUN / REDIR)
//   fetch_entry_t  - {PC, Inst} pair held in the output queue
//   align_word()   - clears the byte-offset bits of an address
package fetch_unit_pkg;

    typedef logic [31:0] int32_t;

    localparam int32_t BUBBLE = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    typedef struct packed {
        int32_t pc;
        int32_t inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);
    localparam int TAG_W   = $bits(int32_t);

    function automatic int32_t align_word(input int32_t a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO with clear.
//   clk, reset      - clock, synchronous active-high reset
//   clear           - empties the FIFO on the next edge (wins over push/pop)
//   push, push_data - write one entry (ignored when full and not popping)
//   pop             - drop the head entry (ignored when empty)
//   head            - current head entry; only meaningful when count != 0
//   count           - number of valid entries, 0..2
module fetch_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset || clear) !(push && !do_push));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset || clear) !(pop && !do_pop));
    a_count_range:  assert property (@(posedge clk) disable iff (reset) count <= 2'd2);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, producer side of the IF/ID register.
// Generates the PC stream, issues word requests to instruction memory, keeps
// the PC of every in-flight request in a tag queue, and buffers returned
// words in a 2-entry output queue whose head drives {Inst, PC}.
//   clk, reset                    - clock, synchronous active-high reset
//   b_taken/b_target, jmp/j_target - redirects (branch wins over jump)
//   stall                         - decode cannot accept; hold Inst/PC
//   imem_req/imem_addr/imem_ready - request channel (handshake on req&&ready)
//   imem_rvalid/imem_rdata        - in-order response channel
//   Inst/PC/inst_valid            - output to IF/ID, all-zero when empty
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int32_t RESET_PC = 32'h0000_0000,
    parameter int     MAX_OUT  = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   b_taken,
    input  int32_t b_target,
    input  logic   jmp,
    input  int32_t j_target,
    input  logic   stall,
    output logic   imem_req,
    output int32_t imem_addr,
    input  logic   imem_ready,
    input  logic   imem_rvalid,
    input  int32_t imem_rdata,
    output int32_t Inst,
    output int32_t PC,
    output logic   inst_valid
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    int32_t       pc_q;
    logic [1:0]   drop_cnt;
    logic [1:0]   outstanding;
    logic [1:0]   fifo_count;
    logic [2:0]   occupancy;
    logic         redirect;
    int32_t       redir_target;
    logic         fire;
    logic         resp;
    logic         resp_keep;
    logic         out_pop;
    int32_t       tag_head;
    fetch_entry_t head_entry;

    // Branch is the older instruction, so it wins over a simultaneous jump.
    assign redirect     = b_taken | jmp;
    assign redir_target = align_word(b_taken ? b_target : j_target);

    assign inst_valid = (fifo_count != 2'd0);
    assign out_pop    = inst_valid && !stall && !redirect;

    // A response with no tag in flight belongs to a request issued before
    // reset; it is ignored.
    assign resp      = imem_rvalid && (outstanding != 2'd0);
    assign resp_keep = resp && (drop_cnt == 2'd0) && !redirect;

    // The word leaving the output queue this cycle frees its slot, which is
    // what sustains one instruction per cycle with a 1-cycle memory.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, out_pop};

    assign fire      = imem_req && imem_ready;
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_BOOT:  state_d  = ST_RUN;
            ST_RUN:   imem_req = !redirect && (occupancy < 3'(MAX_OUT));
            ST_REDIR: state_d  = ST_RUN;
            default:  state_d  = ST_BOOT;
        endcase
        if (redirect) state_d = ST_REDIR;
    end

    always_ff @(posedge clk) begin
        if (reset)         pc_q <= RESET_PC;
        else if (redirect) pc_q <= redir_target;
        else if (fire)     pc_q <= pc_q + 32'd4;
    end

    // Everything still in flight at a redirect is wrong-path. No request is
    // issued in a redirect cycle, so what remains after this edge is the tag
    // count minus any response returning now (which is dropped as well).
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= 2'd0;
        else if (redirect)
            drop_cnt <= outstanding - {1'b0, resp};
        else if (resp && (drop_cnt != 2'd0))
            drop_cnt <= drop_cnt - 2'd1;
    end

    // PC of each request in flight; never cleared, drains as responses return.
    fetch_fifo #(.W(TAG_W)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (fire),
        .push_data (pc_q),
        .pop       (resp),
        .head      (tag_head),
        .count     (outstanding)
    );

    fetch_fifo #(.W(ENTRY_W)) u_out_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (resp_keep),
        .push_data ({tag_head, imem_rdata}),
        .pop       (out_pop),
        .head      (head_entry),
        .count     (fifo_count)
    );

    assign Inst = inst_valid ? head_entry.inst : BUBBLE;
    assign PC   = inst_valid ? head_entry.pc   : BUBBLE;

    a_drop_range: assert property (@(posedge clk) disable iff (reset) drop_cnt <= outstanding);
    a_occ_range:  assert property (@(posedge clk) disable iff (reset)
                                   ({1'b0, outstanding} + {1'b0, fifo_count}) <= 3'(MAX_OUT));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
// of configurable latency and optional imem_ready throttling.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        b_taken;
    logic [31:0] b_target;
    logic        jmp;
    logic [31:0] j_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Inst;
    logic [31:0] PC;
    logic        inst_valid;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .b_taken     (b_taken),
        .b_target    (b_target),
        .jmp         (jmp),
        .j_target    (j_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Inst        (Inst),
        .PC          (PC),
        .inst_valid  (inst_valid)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: responses in order, each no earlier than mem_lat cycles
    // after acceptance, at most one per cycle.
    int          mem_lat      = 1;
    bit          ready_toggle = 1'b0;
    int          mcyc         = 0;
    int          max_inflight = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always @(negedge clk) begin
        if (reset) begin
            q_addr.delete();
            q_due.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            imem_ready  = 1'b1;
        end else begin
            if (q_addr.size() > 0 && q_due[0] <= mcyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mdata(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            imem_ready = ready_toggle ? ((mcyc % 3) != 0) : 1'b1;
            #1;
            if (imem_req && imem_ready) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(mcyc + mem_lat);
            end
            if (q_addr.size() > max_inflight) max_inflight = q_addr.size();
        end
        mcyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 after reset release (FSM in BOOT).
    task automatic do_reset(input int lat, input bit tog);
        reset = 1'b1; stall = 1'b0;
        b_taken = 1'b0; b_target = 32'h0; jmp = 1'b0; j_target = 32'h0;
        mem_lat = lat; ready_toggle = tog; max_inflight = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0;
        b_taken = 1'b0; b_target = 32'h0; jmp = 1'b0; j_target = 32'h0;
        mem_lat = 1; ready_toggle = 1'b0;
        tick(); tick();
        total++;
        if ({inst_valid, PC, Inst, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0})
            $display("FAIL reset_outputs: got v=%b pc=%h inst=%h req=%b addr=%h want all zero",
                     inst_valid, PC, Inst, imem_req, imem_addr);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if ({imem_req, inst_valid} !== 2'b00)
            $display("FAIL boot_no_req: got req=%b v=%b want 0 0", imem_req, inst_valid);
        else passed++;
    endtask

    // Continues from cycle 0 of test_reset; ends in cycle 5 with PC=0x8 at the head.
    task automatic test_fetch();
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL first_req: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h4, 1'b0})
            $display("FAIL second_req: got req=%b addr=%h v=%b want 1 00000004 0", imem_req, imem_addr, inst_valid);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst, imem_addr} !== {1'b1, 32'h0, mdata(32'h0), 32'h8})
            $display("FAIL first_valid: got v=%b pc=%h inst=%h addr=%h want 1 00000000 %h 00000008",
                     inst_valid, PC, Inst, imem_addr, mdata(32'h0));
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h4, mdata(32'h4)})
            $display("FAIL stream_pc4: got v=%b pc=%h inst=%h", inst_valid, PC, Inst);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h8, mdata(32'h8)})
            $display("FAIL stream_pc8: got v=%b pc=%h inst=%h", inst_valid, PC, Inst);
        else passed++;
    endtask

    // Stall in cycles 5..7 while PC=0x8 sits at the head.
    task automatic test_stall();
        stall = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL stall_req_drop: got req=%b want 0", imem_req);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({inst_valid, PC, Inst, imem_req} !== {1'b1, 32'h8, mdata(32'h8), 1'b0})
                $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h req=%b want 1 00000008 %h 0",
                         i, inst_valid, PC, Inst, imem_req, mdata(32'h8));
            else passed++;
        end
        stall = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10})
            $display("FAIL stall_resume_req: got req=%b addr=%h want 1 00000010", imem_req, imem_addr);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({inst_valid, PC, Inst} !== {1'b1, 32'hC + 32'(4 * i), mdata(32'hC + 32'(4 * i))})
                $display("FAIL stall_resume_%0d: got v=%b pc=%h inst=%h want pc=%h",
                         i, inst_valid, PC, Inst, 32'hC + 32'(4 * i));
            else passed++;
        end
    endtask

    // Latency 3 builds up two outstanding requests; jump at R=3 to an
    // unaligned target, memory latency 1 from then on.
    task automatic test_jmp_drop();
        do_reset(3, 1'b0);
        tick(); tick(); tick();
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL jmp_two_outstanding: got req=%b want 0", imem_req);
        else passed++;
        mem_lat = 1; jmp = 1'b1; j_target = 32'h103;
        tick();
        jmp = 1'b0;
        #1;
        total++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 32'h100})
            $display("FAIL jmp_redir: got v=%b req=%b addr=%h want 0 0 00000100", inst_valid, imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL jmp_target_req: got v=%b req=%b addr=%h want 0 1 00000100", inst_valid, imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({inst_valid, imem_addr} !== {1'b0, 32'h104})
            $display("FAIL jmp_dropped: got v=%b addr=%h want 0 00000104", inst_valid, imem_addr);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h100, mdata(32'h100)})
            $display("FAIL jmp_first_valid: got v=%b pc=%h inst=%h want 1 00000100", inst_valid, PC, Inst);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h104, mdata(32'h104)})
            $display("FAIL jmp_second: got v=%b pc=%h inst=%h want 1 00000104", inst_valid, PC, Inst);
        else passed++;
    endtask

    // Branch + jump + stall in cycle 4 with PC=0x4 buffered.
    task automatic test_priority();
        do_reset(1, 1'b0);
        tick(); tick(); tick(); tick();
        total++;
        if ({inst_valid, PC} !== {1'b1, 32'h4})
            $display("FAIL prio_pre: got v=%b pc=%h want 1 00000004", inst_valid, PC);
        else passed++;
        b_taken = 1'b1; b_target = 32'h40; jmp = 1'b1; j_target = 32'h80; stall = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL prio_redirect_req: got req=%b want 0", imem_req);
        else passed++;
        tick();
        b_taken = 1'b0; jmp = 1'b0; stall = 1'b0;
        #1;
        total++;
        if ({inst_valid, PC, Inst, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h40})
            $display("FAIL prio_cleared: got v=%b pc=%h inst=%h req=%b addr=%h want 0 0 0 0 00000040",
                     inst_valid, PC, Inst, imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h40})
            $display("FAIL prio_target_req: got req=%b addr=%h want 1 00000040", imem_req, imem_addr);
        else passed++;
        tick(); tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h40, mdata(32'h40)})
            $display("FAIL prio_first_valid: got v=%b pc=%h inst=%h want 1 00000040", inst_valid, PC, Inst);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC} !== {1'b1, 32'h44})
            $display("FAIL prio_second: got v=%b pc=%h want 1 00000044", inst_valid, PC);
        else passed++;
    endtask

    // Latency 3, imem_ready low one cycle in three, random stalls: every
    // accepted instruction must be the next sequential one with its own word.
    task automatic test_ready_toggle();
        logic [31:0] exp_pc;
        int          got;
        exp_pc = 32'h0;
        got    = 0;
        do_reset(3, 1'b1);
        for (int c = 0; c < 90; c++) begin
            tick();
            stall = ($urandom_range(0, 3) == 0);
            if (inst_valid && !stall) begin
                total++;
                if ({PC, Inst} !== {exp_pc, mdata(exp_pc)})
                    $display("FAIL toggle_order: got pc=%h inst=%h want pc=%h inst=%h", PC, Inst, exp_pc, mdata(exp_pc));
                else passed++;
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        stall = 1'b0;
        total++;
        if (got < 10)
            $display("FAIL toggle_progress: got %0d instructions want >= 10", got);
        else passed++;
        total++;
        if (max_inflight > 2)
            $display("FAIL toggle_outstanding: got %0d in flight want <= 2", max_inflight);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b0);
        tick();
        jmp = 1'b1; j_target = 32'hFFFF_FFF8;
        tick();
        jmp = 1'b0;
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFF8})
            $display("FAIL wrap_req_f8: got req=%b addr=%h want 1 fffffff8", imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_req_fc: got req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({imem_req, imem_addr, inst_valid, PC} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8})
            $display("FAIL wrap_req_0: got req=%b addr=%h v=%b pc=%h want 1 00000000 1 fffffff8",
                     imem_req, imem_addr, inst_valid, PC);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'hFFFF_FFFC, mdata(32'hFFFF_FFFC)})
            $display("FAIL wrap_pc_fc: got v=%b pc=%h inst=%h", inst_valid, PC, Inst);
        else passed++;
        tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h0, mdata(32'h0)})
            $display("FAIL wrap_pc_0: got v=%b pc=%h inst=%h want 1 00000000", inst_valid, PC, Inst);
        else passed++;
    endtask

    // Called mid-stream right after test_wrap.
    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        total++;
        if ({inst_valid, PC, Inst, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0})
            $display("FAIL mid_reset_outputs: got v=%b pc=%h inst=%h req=%b addr=%h want all zero",
                     inst_valid, PC, Inst, imem_req, imem_addr);
        else passed++;
        reset = 1'b0;
        tick();
        total++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL mid_restart_req: got req=%b addr=%h v=%b want 1 00000000 0", imem_req, imem_addr, inst_valid);
        else passed++;
        tick(); tick();
        total++;
        if ({inst_valid, PC, Inst} !== {1'b1, 32'h0, mdata(32'h0)})
            $display("FAIL mid_restart_valid: got v=%b pc=%h inst=%h want 1 00000000", inst_valid, PC, Inst);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_jmp_drop();
        test_priority();
        test_ready_toggle();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
